// File: rtl/cpu_int_pkg.sv
// cpu_int_ctrl shared types: FSM states, register map, STATUS layout.
// Optional ack timeout is enabled by CPU_INT_ACK_TIMEOUT_EN.
package cpu_int_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    SERV = 2'd2
  } state_t;

  localparam logic [1:0] ADDR_MASK   = 2'd0;
  localparam logic [1:0] ADDR_PEND   = 2'd1;
  localparam logic [1:0] ADDR_EDGE   = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  localparam int ST_ID   = 0;
  localparam int ST_REQ  = 2;
  localparam int ST_BUSY = 3;
  localparam int ST_TOUT = 7;

  function automatic logic [7:0] status_word(
    input logic       tout,
    input logic       busy,
    input logic       req,
    input logic [1:0] id
  );
    logic [7:0] w;
    w = '0;
    w[ST_TOUT]         = tout;
    w[ST_BUSY]         = busy;
    w[ST_REQ]          = req;
    w[ST_ID+1:ST_ID]   = id;
    return w;
  endfunction

endpackage

// File: rtl/cpu_int_ctrl_prio_enc.sv
// Fixed-priority encoder: lowest set index wins.
// Part of cpu_int_ctrl (macro CPU_INT_ACK_TIMEOUT_EN lives in the top).
module cpu_int_prio_enc #(
  parameter int N = 4
) (
  input  logic [N-1:0] elig,
  output logic         valid,
  output logic [1:0]   idx
);

  always_comb begin
    valid = |elig;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (elig[i]) idx = 2'(i);
    end
  end

endmodule

// File: rtl/cpu_int_ctrl.sv
// Interrupt controller for the 8-bit cpu: pend/mask/edge regs + req/ack/eoi FSM.
// Define CPU_INT_ACK_TIMEOUT_EN to add the acknowledge timeout and STATUS[7].
module cpu_int_ctrl
  import cpu_int_pkg::*;
#(
  parameter int               N_IRQ       = 4,
  parameter int               VEC_W       = 10,
  parameter logic [VEC_W-1:0] VEC_BASE    = 10'h3F0,
  parameter int               VEC_STRIDE  = 2,
  parameter int               ACK_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_IRQ-1:0] irq_in,
  input  logic             cfg_we,
  input  logic [1:0]       cfg_addr,
  input  logic [7:0]       cfg_wdata,
  output logic [7:0]       cfg_rdata,
  output logic             int_req,
  input  logic             int_ack,
  output logic [VEC_W-1:0] int_vec,
  output logic [1:0]       int_id,
  input  logic             eoi
);

  state_t state, state_d;

  logic [N_IRQ-1:0] mask, pend, emode, irq_q;
  logic [N_IRQ-1:0] pend_d, w1c, ack_clr, rise;
  logic [N_IRQ-1:0] elig;
  logic             enc_valid;
  logic [1:0]       enc_idx;
  logic             cap;
  logic             to_hit;
  logic             tflag;
  logic [VEC_W-1:0] vec_d;

  wire unused_wdata = ^cfg_wdata[7:N_IRQ];

  assign elig = pend & mask;

  cpu_int_prio_enc #(.N(N_IRQ)) u_enc (
    .elig  (elig),
    .valid (enc_valid),
    .idx   (enc_idx)
  );

  assign vec_d = VEC_BASE + VEC_W'(VEC_STRIDE * int'(enc_idx));

  always_comb begin
    state_d = state;
    cap     = 1'b0;
    unique case (state)
      IDLE: begin
        if (enc_valid) begin
          state_d = REQ;
          cap     = 1'b1;
        end
      end
      REQ: begin
        if (int_ack)     state_d = SERV;
        else if (to_hit) state_d = IDLE;
      end
      SERV: begin
        if (eoi) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Set wins over clear: rising edges are OR-ed in after the clears.
  always_comb begin
    w1c     = '0;
    ack_clr = '0;
    if (cfg_we && cfg_addr == ADDR_PEND)
      w1c = cfg_wdata[N_IRQ-1:0];
    if (state == REQ && int_ack)
      ack_clr = (N_IRQ'(1) << int_id) & emode;
    rise   = irq_in & ~irq_q;
    pend_d = (emode & ((pend & ~w1c & ~ack_clr) | rise))
           | (~emode & irq_in);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      mask    <= '0;
      emode   <= '1;
      pend    <= '0;
      irq_q   <= '0;
      int_id  <= '0;
      int_vec <= '0;
    end else begin
      state <= state_d;
      irq_q <= irq_in;
      pend  <= pend_d;
      if (cfg_we && cfg_addr == ADDR_MASK)
        mask <= cfg_wdata[N_IRQ-1:0];
      if (cfg_we && cfg_addr == ADDR_EDGE)
        emode <= cfg_wdata[N_IRQ-1:0];
      if (cap) begin
        int_id  <= enc_idx;
        int_vec <= vec_d;
      end
    end
  end

  assign int_req = (state == REQ);

`ifdef CPU_INT_ACK_TIMEOUT_EN
  logic [7:0] to_cnt;
  logic       st_wr;

  assign st_wr  = cfg_we && cfg_addr == ADDR_STATUS;
  assign to_hit = (state == REQ) && (to_cnt == 8'(ACK_TIMEOUT - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      to_cnt <= '0;
      tflag  <= 1'b0;
    end else begin
      if (state != REQ) to_cnt <= '0;
      else              to_cnt <= to_cnt + 8'd1;
      if (to_hit && !int_ack) tflag <= 1'b1;
      else if (st_wr)         tflag <= 1'b0;
    end
  end
`else
  localparam int unused_ack_to = ACK_TIMEOUT;
  assign to_hit = 1'b0;
  assign tflag  = 1'b0;
`endif

  always_comb begin
    cfg_rdata = '0;
    unique case (cfg_addr)
      ADDR_MASK:   cfg_rdata[N_IRQ-1:0] = mask;
      ADDR_PEND:   cfg_rdata[N_IRQ-1:0] = pend;
      ADDR_EDGE:   cfg_rdata[N_IRQ-1:0] = emode;
      ADDR_STATUS: cfg_rdata = status_word(tflag, state == SERV,
                                           state == REQ, int_id);
      default:     cfg_rdata = '0;
    endcase
  end

endmodule
